// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake, iterative signed MUL/DIV and NZCV-style flags.
// Optional build macro FAST_MUL_EN swaps the iterative multiply for a single-cycle combinational one.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] peripheral_value,
   input  logic [1:0]       TypeCode,
   input  logic [3:0]       OpCode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                          OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NEG = 4'd7,
                          OP_MOV = 4'd8, OP_PER = 4'd9;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               neg_q;
   logic [2*WIDTH-1:0] acc, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo, dvsr;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               go_mul, go_div;
   logic [WIDTH:0]     sum, diff;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_carry, sc_ovf, sc_dbz;
   logic [2*WIDTH-1:0] acc_nx, mul_full;
   logic [WIDTH:0]     rem_sh, rem_nx;
   logic [WIDTH-1:0]   quo_nx, div_res;
   logic               div_ge;
   logic               commit;
   logic [WIDTH-1:0]   c_res;
   logic               c_carry, c_ovf, c_dbz;

   // A signed product fits in WIDTH bits only if its top WIDTH+1 bits are all equal.
   function automatic logic prod_ovf(input logic [2*WIDTH-1:0] p);
      return (|p[2*WIDTH-1:WIDTH-1]) && !(&p[2*WIDTH-1:WIDTH-1]);
   endfunction

   assign mag_a = A[WIDTH-1] ? -A : A;
   assign mag_b = B[WIDTH-1] ? -B : B;
   assign sum   = {1'b0, A} + {1'b0, B};
   assign diff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

`ifdef FAST_MUL_EN
   logic signed [2*WIDTH-1:0] fast_prod;
   assign fast_prod = $signed(A) * $signed(B);
   assign go_mul    = 1'b0;
`else
   assign go_mul    = (TypeCode == 2'b00) && (OpCode == OP_MUL);
`endif
   assign go_div    = (TypeCode == 2'b00) && (OpCode == OP_DIV) && (B != '0);

   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      sc_dbz   = 1'b0;
      if (TypeCode != 2'b00) begin
         sc_res = B;
      end else begin
         case (OpCode)
            OP_ADD: begin
               sc_res   = sum[WIDTH-1:0];
               sc_carry = sum[WIDTH];
               sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
               sc_res   = diff[WIDTH-1:0];
               sc_carry = diff[WIDTH];
               sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_XOR: sc_res = A ^ B;
            OP_NEG: begin
               sc_res = -A;
               sc_ovf = (A == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_MOV: sc_res = B;
            OP_PER: sc_res = peripheral_value;
            // Only a divide by zero takes the single-cycle path.
            OP_DIV: sc_dbz = 1'b1;
`ifdef FAST_MUL_EN
            OP_MUL: begin
               sc_res = fast_prod[WIDTH-1:0];
               sc_ovf = prod_ovf(fast_prod);
            end
`endif
            default: sc_res = '0;
         endcase
      end
   end

   always_comb begin
      acc_nx   = mplier[0] ? acc + mcand : acc;
      mul_full = neg_q ? -acc_nx : acc_nx;
      rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
      div_ge   = rem_sh >= {1'b0, dvsr};
      rem_nx   = div_ge ? rem_sh - {1'b0, dvsr} : rem_sh;
      quo_nx   = {quo[WIDTH-2:0], div_ge};
      div_res  = neg_q ? -quo_nx : quo_nx;
   end

   always_comb begin
      commit  = 1'b0;
      c_res   = sc_res;
      c_carry = sc_carry;
      c_ovf   = sc_ovf;
      c_dbz   = sc_dbz;
      case (state)
         MUL: begin
            commit  = (cnt == '0);
            c_res   = mul_full[WIDTH-1:0];
            c_carry = 1'b0;
            c_ovf   = prod_ovf(mul_full);
            c_dbz   = 1'b0;
         end
         DIV: begin
            // Only MIN / -1 leaves a positive quotient with its top bit set.
            commit  = (cnt == '0);
            c_res   = div_res;
            c_carry = 1'b0;
            c_ovf   = !neg_q && quo_nx[WIDTH-1];
            c_dbz   = 1'b0;
         end
         default: commit = start && !go_mul && !go_div;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         neg_q       <= 1'b0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         result      <= '0;
         negative    <= 1'b0;
         zero        <= 1'b0;
         carry       <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         if (commit) begin
            result      <= c_res;
            negative    <= c_res[WIDTH-1];
            zero        <= (c_res == '0);
            carry       <= c_carry;
            overflow    <= c_ovf;
            div_by_zero <= c_dbz;
         end
         case (state)
            MUL: begin
               acc    <= acc_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) state <= FIN;
            end
            DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIN;
            end
            default: begin
               state <= IDLE;
               if (start) begin
                  neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  cnt   <= CW'(WIDTH - 1);
                  if (go_mul) begin
                     state  <= MUL;
                     acc    <= '0;
                     mcand  <= {{WIDTH{1'b0}}, mag_a};
                     mplier <= mag_b;
                  end else if (go_div) begin
                     state <= DIV;
                     rem   <= '0;
                     quo   <= mag_a;
                     dvsr  <= mag_b;
                  end else begin
                     state <= FIN;
                  end
               end
            end
         endcase
      end
   end

   assign done = (state == FIN);
   assign busy = (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: random and directed ops checked against a longint arithmetic model through
// an expected-result queue drained by a monitor on every done pulse.
module tb_seq_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0, B = '0, pv = '0;
   logic [1:0]   tc = 2'b00;
   logic [3:0]   op = 4'd0;
   logic         busy, done, negative, zero, carry, overflow, div_by_zero;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat;

   logic [W-1:0] exp_q[$];
   logic [4:0]   exp_flags_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] mon_res;
   logic [4:0]   mon_flags;
   int           mon_cyc;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .peripheral_value(pv), .TypeCode(tc), .OpCode(op),
      .busy(busy), .done(done), .result(result), .negative(negative), .zero(zero),
      .carry(carry), .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain signed/unsigned 64-bit arithmetic on the operand values.
   function automatic void model(input logic [W-1:0] a, b, p, input logic [1:0] t,
                                 input logic [3:0] o, output logic [W-1:0] res,
                                 output logic [4:0] flags, output int l);
      longint sa, sb, ua, ub, full, mx, mn;
      logic c, v, dz;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      mx = (longint'(1) <<< (W - 1)) - 1;
      mn = -mx - 1;
      c = 1'b0; v = 1'b0; dz = 1'b0; l = 1; full = 0;
      if (t != 2'b00) full = ub;
      else begin
         case (o)
            4'd0: begin full = sa + sb; v = (full > mx) || (full < mn); c = (ua + ub) >= (longint'(1) <<< W); end
            4'd1: begin full = sa - sb; v = (full > mx) || (full < mn); c = (ua >= ub); end
            4'd2: begin
               full = sa * sb; v = (full > mx) || (full < mn);
`ifdef FAST_MUL_EN
               l = 1;
`else
               l = W + 1;
`endif
            end
            4'd3: begin
               if (sb == 0) begin full = 0; dz = 1'b1; end
               else begin full = sa / sb; v = (full > mx); l = W + 1; end
            end
            4'd4: full = ua & ub;
            4'd5: full = ua | ub;
            4'd6: full = ua ^ ub;
            4'd7: begin full = -sa; v = (full > mx); end
            4'd8: full = ub;
            4'd9: full = longint'(p);
            default: full = 0;
         endcase
      end
      res = full[W-1:0];
      flags = {res[W-1], (res == '0), c, v, dz};
   endfunction

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return {1'b1, {(W-1){1'b0}}};
         2: return {1'b0, {(W-1){1'b1}}};
         3: return '1;
         4: return W'($signed($urandom_range(0, 40)) - 20);
         default: return W'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [W-1:0] a, b, p, input logic [1:0] t, input logic [3:0] o,
                        output int l);
      logic [W-1:0] er;
      logic [4:0]   ef;
      model(a, b, p, t, o, er, ef, l);
      exp_q.push_back(er);
      exp_flags_q.push_back(ef);
      exp_cyc_q.push_back(cyc + l);
      A = a; B = b; pv = p; tc = t; op = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); pv = W'($urandom);
      op = 4'($urandom_range(0, 15)); tc = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(input int l, input bit chk_busy);
      int  nbusy = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) nbusy++;
            @(negedge clk);
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      if (chk_busy) check("busy_cycles", 64'(nbusy), (l > 1) ? 64'(W) : 64'd0);
   endtask

   // Monitor: every done pulse must match the oldest expected entry, including its cycle.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
         else begin
            mon_res   = exp_q.pop_front();
            mon_flags = exp_flags_q.pop_front();
            mon_cyc   = exp_cyc_q.pop_front();
            check("result", 64'(result), 64'(mon_res));
            check("flags_nzcvd", 64'({negative, zero, carry, overflow, div_by_zero}), 64'(mon_flags));
            check("done_cycle", 64'(cyc), 64'(mon_cyc));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({busy, done, result, negative, zero, carry, overflow, div_by_zero}), 64'd0);
      reset = 1'b0;

      // Directed corner cases
      issue(32'h7FFFFFFF, 32'd1, '0, 2'b00, 4'd0, lat); wait_done(lat, 1);
      issue(32'hFFFFFFFF, 32'd1, '0, 2'b00, 4'd0, lat); wait_done(lat, 1);
      issue(32'd3, 32'd5, '0, 2'b00, 4'd1, lat);        wait_done(lat, 1);
      issue(32'd5, 32'd3, '0, 2'b00, 4'd1, lat);        wait_done(lat, 1);
      issue(-32'sd6, 32'd7, '0, 2'b00, 4'd2, lat);      wait_done(lat, 1);
      issue(32'h10000, 32'h10000, '0, 2'b00, 4'd2, lat); wait_done(lat, 1);
      issue(-32'sd7, 32'd2, '0, 2'b00, 4'd3, lat);      wait_done(lat, 1);
      issue(32'd9, 32'd0, '0, 2'b00, 4'd3, lat);        wait_done(lat, 1);
      issue(32'h80000000, 32'hFFFFFFFF, '0, 2'b00, 4'd3, lat); wait_done(lat, 1);
      issue(32'h80000000, 32'd0, '0, 2'b00, 4'd7, lat); wait_done(lat, 1);
      issue(32'd1, 32'd2, 32'hCAFE0001, 2'b00, 4'd9, lat); wait_done(lat, 1);
      issue(32'd1, 32'd2, '0, 2'b00, 4'd13, lat);       wait_done(lat, 1);
      issue(32'd77, 32'h1000, '0, 2'b01, 4'd0, lat);    wait_done(lat, 1);

      // A start during a divide must be ignored
      issue(32'd100, 32'd7, '0, 2'b00, 4'd3, lat);
      repeat (10) @(negedge clk);
      A = 32'd1; B = 32'h555; tc = 2'b00; op = 4'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, 0);

      // Reset five cycles into a multiply, with a start held during the reset cycle
      A = 32'd7; B = 32'd3; tc = 2'b00; op = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1; op = 4'd0; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("reset_mid_op", 64'({busy, done, result, negative, zero, carry, overflow, div_by_zero}), 64'd0);
      repeat (40) @(negedge clk);
      issue(32'd20, 32'd22, '0, 2'b00, 4'd0, lat); wait_done(lat, 1);

      // Back-to-back single-cycle ops
      for (int i = 0; i < 8; i++) begin
         logic [3:0] o;
         o = 4'($urandom_range(4, 15));
         if (i % 3 == 0) o = 4'(i % 2);
         issue(rand_operand(), rand_operand(), W'($urandom), 2'b00, o, lat);
      end
      wait_done(1, 0);
      repeat (2) @(negedge clk);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         logic [1:0] t;
         t = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         issue(rand_operand(), rand_operand(), W'($urandom), t, 4'($urandom_range(0, 15)), lat);
         wait_done(lat, 1);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
